dfe_cfg_ctrl: RTL

DFE_CFG_CTRL -- requirements
Module: dfe_cfg_ctrl

---
 rtl/dfe_cfg_pkg.sv | 60 ++++++
 rtl/dfe_cfg_ctrl_if.sv | 39 +++
 rtl/dfe_cfg_fsm.sv | 93 +++++++++
 rtl/dfe_cfg_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dfe_cfg_pkg.sv
// +----------------------------------------------------------------------------+
// | dfe_cfg_pkg : address map, group/state enums and helpers for dfe_cfg_ctrl  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package dfe_cfg_pkg;

    localparam logic [7:0] TAP_BASE     = 8'h00;
    localparam logic [7:0] NUM_2_4_BASE = 8'h48;
    localparam logic [7:0] DEN_2_4_BASE = 8'h4B;
    localparam logic [7:0] NUM_2_BASE   = 8'h4D;
    localparam logic [7:0] DEN_2_BASE   = 8'h50;
    localparam logic [7:0] NUM_1_BASE   = 8'h52;
    localparam logic [7:0] DEN_1_BASE   = 8'h55;
    localparam logic [7:0] CTRL_ADDR    = 8'h57;

    // Coefficient words live at 0x00..0x56; control is held separately
    localparam int SHADOW_WORDS = 87;
    localparam int NUM_GROUPS   = 8;

    typedef enum logic [3:0] {
        GRP_TAP     = 4'd0,
        GRP_NUM_2_4 = 4'd1,
        GRP_DEN_2_4 = 4'd2,
        GRP_NUM_2   = 4'd3,
        GRP_DEN_2   = 4'd4,
        GRP_NUM_1   = 4'd5,
        GRP_DEN_1   = 4'd6,
        GRP_CTRL    = 4'd7,
        GRP_NONE    = 4'd8
    } grp_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    function automatic logic is_legal_factor(input logic [4:0] f);
        return (f == 5'd1) || (f == 5'd2) || (f == 5'd4) ||
               (f == 5'd8) || (f == 5'd16);
    endfunction

    function automatic grp_e addr_group(input logic [7:0] a);
        if      (a < NUM_2_4_BASE) return GRP_TAP;
        else if (a < DEN_2_4_BASE) return GRP_NUM_2_4;
        else if (a < NUM_2_BASE)   return GRP_DEN_2_4;
        else if (a < DEN_2_BASE)   return GRP_NUM_2;
        else if (a < NUM_1_BASE)   return GRP_DEN_2;
        else if (a < DEN_1_BASE)   return GRP_NUM_1;
        else if (a < CTRL_ADDR)    return GRP_DEN_1;
        else if (a == CTRL_ADDR)   return GRP_CTRL;
        else                       return GRP_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dfe_cfg_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | dfe_cfg_ctrl_if : configuration write/commit bus (optional readback under  |
// | DFE_CFG_READBACK_EN). Rev 1.0                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dfe_cfg_ctrl_if #(
    parameter int COEFF_WIDTH = 20
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [7:0]             cfg_addr;
    logic [COEFF_WIDTH-1:0] cfg_wdata;
    logic                   cfg_commit;
    logic                   cfg_err;
    logic                   busy;
`ifdef DFE_CFG_READBACK_EN
    logic [COEFF_WIDTH-1:0] cfg_rdata;
`endif

    modport master (
        output cfg_valid, cfg_addr, cfg_wdata, cfg_commit,
        input  cfg_ready, cfg_err, busy
`ifdef DFE_CFG_READBACK_EN
        , input cfg_rdata
`endif
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_wdata, cfg_commit,
        output cfg_ready, cfg_err, busy
`ifdef DFE_CFG_READBACK_EN
        , output cfg_rdata
`endif
    );

endinterface

`default_nettype wire

// File: rtl/dfe_cfg_fsm.sv
// +----------------------------------------------------------------------------+
// | dfe_cfg_fsm : commit sequencer (IDLE/DRAIN/LOAD/SETTLE) with valid gating  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module dfe_cfg_fsm
    import dfe_cfg_pkg::*;
#(
    parameter int DRAIN_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic commit,
    input  logic any_dirty,
    input  logic valid_in_up,
    output logic ready,
    output logic busy,
    output logic valid_in,
    output logic load_start
);

    localparam int c_MAX_CYC = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST  = c_CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE         = c_CNT_W'(1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        load_start  = 1'b0;
        ready       = 1'b0;
        busy        = 1'b1;
        valid_in    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready    = 1'b1;
                busy     = 1'b0;
                valid_in = valid_in_up;
                if (commit && any_dirty) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DRAIN: begin
                // Last drain cycle launches the register capture that appears in LOAD
                if (r_cnt == c_DRAIN_LAST) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                    load_start  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_SETTLE;
                w_cnt_nxt   = '0;
            end
            ST_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dfe_cfg_ctrl.sv
// +----------------------------------------------------------------------------+
// | dfe_cfg_ctrl : shadowed DFE coefficient/control config with drained commit |
// | Optional readback port: DFE_CFG_READBACK_EN.  Rev 1.0                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module dfe_cfg_ctrl
    import dfe_cfg_pkg::*;
#(
    parameter int COEFF_WIDTH     = 20,
    parameter int N_TAP           = 72,
    parameter int NUM_COEFF_DEPTH = 3,
    parameter int DEN_COEFF_DEPTH = 2,
    parameter int DRAIN_CYCLES    = 16,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    dfe_cfg_ctrl_if.slave                 cfg,
    input  logic                          valid_in_up,
    output logic                          valid_in,
    output logic                          frac_dec_coeff_wr_en,
    output logic signed [COEFF_WIDTH-1:0] frac_dec_coeff_data_in [N_TAP],
    output logic                          iir_num_coeff_2_4_wr_en,
    output logic signed [COEFF_WIDTH-1:0] iir_num_coeff_2_4_in [NUM_COEFF_DEPTH],
    output logic                          iir_den_coeff_2_4_wr_en,
    output logic signed [COEFF_WIDTH-1:0] iir_den_coeff_2_4_in [DEN_COEFF_DEPTH],
    output logic                          iir_num_coeff_2_wr_en,
    output logic signed [COEFF_WIDTH-1:0] iir_num_coeff_2_in [NUM_COEFF_DEPTH],
    output logic                          iir_den_coeff_2_wr_en,
    output logic signed [COEFF_WIDTH-1:0] iir_den_coeff_2_in [DEN_COEFF_DEPTH],
    output logic                          iir_num_coeff_1_wr_en,
    output logic signed [COEFF_WIDTH-1:0] iir_num_coeff_1_in [NUM_COEFF_DEPTH],
    output logic                          iir_den_coeff_1_wr_en,
    output logic signed [COEFF_WIDTH-1:0] iir_den_coeff_1_in [DEN_COEFF_DEPTH],
    output logic                          iir_bypass_2_4,
    output logic                          iir_bypass_2,
    output logic                          iir_bypass_1,
    output logic [4:0]                    cic_dec_factor
);

    logic [COEFF_WIDTH-1:0] r_shadow [SHADOW_WORDS];
    logic [7:0]             r_shadow_ctrl;
    logic [NUM_GROUPS-1:0]  r_dirty;
    logic                   r_err;

    logic                   w_ready;
    logic                   w_busy;
    logic                   w_load_start;
    logic                   w_accept;
    logic                   w_illegal;
    logic                   w_write;
    logic                   w_any_dirty;
    grp_e                   w_grp;

    assign w_grp     = addr_group(cfg.cfg_addr);
    assign w_accept  = cfg.cfg_valid & w_ready;
    assign w_illegal = (w_grp == GRP_NONE) ||
                       ((w_grp == GRP_CTRL) && !is_legal_factor(cfg.cfg_wdata[4:0]));
    assign w_write   = w_accept & ~w_illegal;
    // A write landing in the commit cycle counts toward that commit
    assign w_any_dirty = (|r_dirty) | w_write;

    assign cfg.cfg_ready = w_ready;
    assign cfg.busy      = w_busy;
    assign cfg.cfg_err   = r_err;

    dfe_cfg_fsm #(
        .DRAIN_CYCLES  (DRAIN_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit      (cfg.cfg_commit),
        .any_dirty   (w_any_dirty),
        .valid_in_up (valid_in_up),
        .ready       (w_ready),
        .busy        (w_busy),
        .valid_in    (valid_in),
        .load_start  (w_load_start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SHADOW_WORDS; i++) r_shadow[i] <= '0;
            r_shadow_ctrl <= '0;
            r_dirty       <= '0;
            r_err         <= 1'b0;
        end else begin
            r_err <= w_accept & w_illegal;
            // Writes are blocked outside IDLE, so a load never races a write
            if (w_load_start) begin
                r_dirty <= '0;
            end else if (w_write) begin
                r_dirty[w_grp[2:0]] <= 1'b1;
            end
            if (w_write) begin
                if (w_grp == GRP_CTRL) r_shadow_ctrl <= cfg.cfg_wdata[7:0];
                else                   r_shadow[cfg.cfg_addr[6:0]] <= cfg.cfg_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAP; i++) frac_dec_coeff_data_in[i] <= '0;
            for (int i = 0; i < NUM_COEFF_DEPTH; i++) begin
                iir_num_coeff_2_4_in[i] <= '0;
                iir_num_coeff_2_in[i]   <= '0;
                iir_num_coeff_1_in[i]   <= '0;
            end
            for (int i = 0; i < DEN_COEFF_DEPTH; i++) begin
                iir_den_coeff_2_4_in[i] <= '0;
                iir_den_coeff_2_in[i]   <= '0;
                iir_den_coeff_1_in[i]   <= '0;
            end
            frac_dec_coeff_wr_en    <= 1'b0;
            iir_num_coeff_2_4_wr_en <= 1'b0;
            iir_den_coeff_2_4_wr_en <= 1'b0;
            iir_num_coeff_2_wr_en   <= 1'b0;
            iir_den_coeff_2_wr_en   <= 1'b0;
            iir_num_coeff_1_wr_en   <= 1'b0;
            iir_den_coeff_1_wr_en   <= 1'b0;
            iir_bypass_2_4          <= 1'b0;
            iir_bypass_2            <= 1'b0;
            iir_bypass_1            <= 1'b0;
            cic_dec_factor          <= 5'd1;
        end else begin
            frac_dec_coeff_wr_en    <= w_load_start & r_dirty[int'(GRP_TAP)];
            iir_num_coeff_2_4_wr_en <= w_load_start & r_dirty[int'(GRP_NUM_2_4)];
            iir_den_coeff_2_4_wr_en <= w_load_start & r_dirty[int'(GRP_DEN_2_4)];
            iir_num_coeff_2_wr_en   <= w_load_start & r_dirty[int'(GRP_NUM_2)];
            iir_den_coeff_2_wr_en   <= w_load_start & r_dirty[int'(GRP_DEN_2)];
            iir_num_coeff_1_wr_en   <= w_load_start & r_dirty[int'(GRP_NUM_1)];
            iir_den_coeff_1_wr_en   <= w_load_start & r_dirty[int'(GRP_DEN_1)];
            if (w_load_start) begin
                if (r_dirty[int'(GRP_TAP)])
                    for (int i = 0; i < N_TAP; i++)
                        frac_dec_coeff_data_in[i] <= r_shadow[int'(TAP_BASE) + i];
                if (r_dirty[int'(GRP_NUM_2_4)])
                    for (int i = 0; i < NUM_COEFF_DEPTH; i++)
                        iir_num_coeff_2_4_in[i] <= r_shadow[int'(NUM_2_4_BASE) + i];
                if (r_dirty[int'(GRP_DEN_2_4)])
                    for (int i = 0; i < DEN_COEFF_DEPTH; i++)
                        iir_den_coeff_2_4_in[i] <= r_shadow[int'(DEN_2_4_BASE) + i];
                if (r_dirty[int'(GRP_NUM_2)])
                    for (int i = 0; i < NUM_COEFF_DEPTH; i++)
                        iir_num_coeff_2_in[i] <= r_shadow[int'(NUM_2_BASE) + i];
                if (r_dirty[int'(GRP_DEN_2)])
                    for (int i = 0; i < DEN_COEFF_DEPTH; i++)
                        iir_den_coeff_2_in[i] <= r_shadow[int'(DEN_2_BASE) + i];
                if (r_dirty[int'(GRP_NUM_1)])
                    for (int i = 0; i < NUM_COEFF_DEPTH; i++)
                        iir_num_coeff_1_in[i] <= r_shadow[int'(NUM_1_BASE) + i];
                if (r_dirty[int'(GRP_DEN_1)])
                    for (int i = 0; i < DEN_COEFF_DEPTH; i++)
                        iir_den_coeff_1_in[i] <= r_shadow[int'(DEN_1_BASE) + i];
                if (r_dirty[int'(GRP_CTRL)]) begin
                    cic_dec_factor <= r_shadow_ctrl[4:0];
                    iir_bypass_2_4 <= r_shadow_ctrl[5];
                    iir_bypass_2   <= r_shadow_ctrl[6];
                    iir_bypass_1   <= r_shadow_ctrl[7];
                end
            end
        end
    end

`ifdef DFE_CFG_READBACK_EN
    always_comb begin
        cfg.cfg_rdata = '0;
        if (cfg.cfg_addr < CTRL_ADDR)
            cfg.cfg_rdata = r_shadow[cfg.cfg_addr[6:0]];
        else if (cfg.cfg_addr == CTRL_ADDR)
            cfg.cfg_rdata = COEFF_WIDTH'(r_shadow_ctrl);
    end
`endif

endmodule

`default_nettype wire
